pdm_block_tx: RTL
=================

// Module: pdm_block_tx
// PURPOSE
//  Transmit end of the PDM audio path: converts reconstructed Q16.16 samples (ifft real outputs) into a
//  1-bit PDM stream for the amplifier, paced by the same clk/CLK_DIV bit clock the mic receiver uses.
//  Buffers words in a small FIFO, runs a first-order sigma-delta modulator and handles underrun and stop.
// PARAMETERS
//  CLK_DIV     32  clk cycles per PDM bit; power of 2, >=4 (100 MHz/32 = 3.125 MHz)
//  OSR         16  PDM bits emitted per input sample; >=2
//  FIFO_DEPTH  4   sample FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1   system clock, single clock domain
//  rst          in   1   synchronous, active-high reset
//  enable       in   1   1 = run/start transmission; 0 = stop after current sample
//  s_valid      in   1   input sample valid
//  s_ready      out  1   FIFO can accept (not full)
//  s_data       in   32  signed Q16.16 sample
//  bit_clk      out  1   PDM bit clock, 50% duty, = divider MSB
//  amp_pwm      out  1   PDM data bit to amplifier
//  amp_sd       out  1   amplifier enable (1 in RUN/STARVE)
//  underrun     out  1   one-clk pulse when a sample boundary finds FIFO empty while running
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset: div=0, FIFO empty, acc=0, state IDLE; bit_clk=0, amp_pwm=0, amp_sd=0, underrun=0, busy=0, s_ready=1.
//  Divider: free-running 0..CLK_DIV-1; tick = (div==CLK_DIV-1); bit_clk = div[MSB].
//  All modulator/state updates occur only on tick; amp_pwm registered, changes the clk after the tick.
//  Input: write when s_valid&&s_ready; s_ready = !full (combinational from count). Push and pop in the
//   same clk on a full FIFO are legal only because s_ready=0 blocks the push; on non-full, both happen,
//   count unchanged. Data order preserved.
//  Clamp: u = 0 if s_data<0; 65536 if s_data>=0x0001_0000; else s_data[16:0]. u is 17 bits.
//  Modulator per tick: sum = acc + u (17 bits); if sum>=65536 {amp_pwm=1; acc=sum-65536} else
//   {amp_pwm=0; acc=sum}. acc stays in [0,65535].
//  Bit counter bcnt 0..OSR-1 counts ticks within a sample; sample boundary = tick with bcnt==OSR-1.
//  FSM:
//   IDLE:  amp_pwm=0, amp_sd=0. On tick with enable && !empty: pop, acc=0, bcnt=0, modulate popped
//          sample this tick -> RUN.
//   RUN:   modulate current sample each tick. At boundary: if !enable -> IDLE (amp_pwm=0);
//          else if !empty pop next -> RUN; else underrun pulse, -> STARVE.
//   STARVE: modulate u=32768 (mid-scale silence). At boundary: if !enable -> IDLE; else if !empty pop
//          -> RUN; else underrun pulse again, stay STARVE.
//  enable drop mid-sample: current sample completes all OSR bits, then IDLE; FIFO contents retained.
//  rst mid-operation: everything returns to reset values next clk, FIFO flushed, no underrun pulse.
//  underrun coincident with s_valid push: push lands; data used at the next boundary (no same-tick bypass).
// CONFIGURATION
//  PDM_TX_UNDERRUN_CNT_EN defined: adds port underrun_cnt out 16, saturating count of underrun pulses,
//   cleared only by rst, holds at 0xFFFF. Undefined: port and counter absent; underrun pulse unchanged.
// TESTING
//  1 rst, enable=1, push 0x0000_8000 -> after first tick amp_pwm = 0,1,0,1.. for 16 bits; amp_sd=1.
//  2 push 0x0001_0000 then 0xFFFF_0000 -> 16 ones then 16 zeros (clamp both ends); 0x0000_4000 -> 0,0,0,1 x4.
//  3 push one word, no more -> underrun pulses once at first boundary, 16 bits alternate 0/1 (mid-scale),
//    pulses each further boundary; with CNT_EN, underrun_cnt increments 1,2,3.
//  4 fill FIFO with 4 words while enable=0 -> s_ready=0, 5th s_valid not accepted; enable=1 -> 4 samples
//    emitted in push order, 64 bits, then underrun.
//  5 drop enable at bit 5 of a sample -> remaining 11 bits emitted, then IDLE, amp_pwm=0, amp_sd=0, busy=0.
//  6 assert rst during RUN -> next clk all outputs at reset values, s_ready=1; bit_clk period = 32 clk.

Source files
------------

// File: rtl/pdm_block_tx.sv
// Sample FIFO + first-order sigma-delta modulator driving a 1-bit PDM amplifier stream (PDM_TX_UNDERRUN_CNT_EN adds underrun_cnt).
// Latency: a pushed sample starts modulating at the first bit tick after it lands; amp_pwm updates one clk after each tick.
// Backpressure: s_ready = FIFO not full; when the FIFO runs dry the modulator plays mid-scale silence and pulses underrun.

// Small synchronous FIFO holding the incoming samples.
module pdm_block_tx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_vld,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          wr_en;
    logic          rd_en;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign wr_en  = wr_vld && !full;
    assign rd_en  = rd_vld && !empty;
    assign rd_dat = mem[rptr];

    // Storage array: written on accepted pushes, needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_dat;
    end

    // Pointers and occupancy; simultaneous push and pop leave cnt unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

module pdm_block_tx #(
    parameter int CLK_DIV    = 32,
    parameter int OSR        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        bit_clk,
    output logic        amp_pwm,
    output logic        amp_sd,
    output logic        underrun,
    output logic        busy
`ifdef PDM_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = (OSR > 1) ? $clog2(OSR) : 1;

    typedef enum logic [1:0] {IDLE, RUN, STARVE} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [BW-1:0] bcnt;
    logic [15:0]   acc;
    logic [16:0]   cur_u;
    logic          tick;
    logic          boundary;
    logic          pop;
    logic          starve_hit;
    logic          full;
    logic          empty;
    logic [31:0]   fifo_dat;
    logic [16:0]   head_u;
    logic [16:0]   mod_u;
    logic [15:0]   mod_acc;
    logic [16:0]   sum;

    // Saturate the Q16.16 sample into the unsigned 0..1.0 modulator range.
    function automatic logic [16:0] clamp_u(input logic [31:0] d);
        if (d[31])              return 17'h0_0000;
        else if (d[30:16] != 0) return 17'h1_0000;
        else                    return {1'b0, d[15:0]};
    endfunction

    pdm_block_tx_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s_valid),
        .wr_dat (s_data),
        .rd_vld (pop),
        .rd_dat (fifo_dat),
        .full   (full),
        .empty  (empty)
    );

    assign s_ready    = !full;
    assign bit_clk    = div[DW-1];
    assign busy       = (state != IDLE);
    assign tick       = (div == DW'(CLK_DIV - 1));
    assign boundary   = (bcnt == BW'(OSR - 1));
    assign head_u     = clamp_u(fifo_dat);
    // A new sample is taken at an idle start or at the end of the current sample.
    assign pop        = tick && enable && !empty && ((state == IDLE) || boundary);
    assign starve_hit = tick && (state != IDLE) && boundary && enable && empty;

    // Modulator operand select: a fresh start uses the FIFO head with a cleared accumulator.
    always_comb begin
        mod_u   = cur_u;
        mod_acc = acc;
        if (state == IDLE) begin
            mod_u   = head_u;
            mod_acc = '0;
        end else if (state == STARVE) begin
            mod_u   = 17'h0_8000;
        end
        sum = {1'b0, mod_acc} + mod_u;
    end

    // Free-running bit clock divider.
    always_ff @(posedge clk) begin
        if (rst) div <= '0;
        else     div <= div + DW'(1);
    end

    // Transmit FSM and modulator; state only advances on bit ticks, underrun is a one-clk pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            bcnt     <= '0;
            cur_u    <= '0;
            amp_pwm  <= 1'b0;
            amp_sd   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (tick) begin
                if (state == IDLE) begin
                    if (pop) begin
                        cur_u   <= head_u;
                        acc     <= sum[15:0];
                        amp_pwm <= sum[16];
                        bcnt    <= BW'(1);
                        amp_sd  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        amp_pwm <= 1'b0;
                        amp_sd  <= 1'b0;
                    end
                end else begin
                    // The last bit of a sample is still emitted when stopping; the following idle tick silences the amp.
                    acc     <= sum[15:0];
                    amp_pwm <= sum[16];
                    if (boundary) begin
                        bcnt <= '0;
                        if (!enable) begin
                            state <= IDLE;
                        end else if (pop) begin
                            cur_u <= head_u;
                            state <= RUN;
                        end else begin
                            underrun <= 1'b1;
                            state    <= STARVE;
                        end
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
            end
        end
    end

`ifdef PDM_TX_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)                                      underrun_cnt <= '0;
        else if (starve_hit && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule
